// File: rtl/vr_fifo.sv
// vr_fifo: valid/ready FIFO with occupancy level, almost-full/empty flags and synchronous flush.
// Define VR_FIFO_BYPASS_EN to compile in the zero-latency empty-FIFO bypass.
module vr_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 10,
  parameter int AF_LEVEL = DEPTH-2,
  parameter int AE_LEVEL = 1,
  localparam int LVL_W   = $clog2(DEPTH+1)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clear_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             up_ready_o,
  output logic             dn_valid_o,
  output logic [WIDTH-1:0] dn_data_o,
  input  logic             dn_ready_i,
  output logic [LVL_W-1:0] level_o,
  output logic             almost_full_o,
  output logic             almost_empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH-1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic wr_lap, rd_lap, empty, full, wr, rd, wr_st, rd_st;
  assign empty = (wr_ptr == rd_ptr) && (wr_lap == rd_lap);
  assign full = (wr_ptr == rd_ptr) && (wr_lap != rd_lap);
  assign up_ready_o = ~full & ~clear_i;
  assign wr = up_valid_i & up_ready_o;
  assign rd = dn_valid_o & dn_ready_i;
`ifdef VR_FIFO_BYPASS_EN
  // an empty FIFO forwards the upstream word; it is stored only if downstream stalls
  assign dn_valid_o = (~empty | up_valid_i) & ~clear_i;
  assign dn_data_o = empty ? up_data_i : mem[rd_ptr];
  assign wr_st = wr & ~(empty & dn_ready_i);
  assign rd_st = rd & ~empty;
`else
  assign dn_valid_o = ~empty & ~clear_i;
  assign dn_data_o = mem[rd_ptr];
  assign wr_st = wr;
  assign rd_st = rd;
`endif
  assign almost_full_o = level_o >= LVL_W'(AF_LEVEL);
  assign almost_empty_o = level_o <= LVL_W'(AE_LEVEL);
  always_ff @(posedge clk_i)
    if (wr_st) mem[wr_ptr] <= up_data_i;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      wr_lap <= 1'b0;
      rd_lap <= 1'b0;
      level_o <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      wr_lap <= 1'b0;
      rd_lap <= 1'b0;
      level_o <= '0;
    end else begin
      if (wr_st) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        wr_lap <= wr_lap ^ (wr_ptr == LAST);
      end
      if (rd_st) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
        rd_lap <= rd_lap ^ (rd_ptr == LAST);
      end
      if (wr_st != rd_st) level_o <= wr_st ? level_o + 1'b1 : level_o - 1'b1;
    end
endmodule

// File: tb/tb_vr_fifo.sv
// tb_vr_fifo: directed self-checking bench for vr_fifo (DEPTH=10, WIDTH=8), bypass-aware.
module tb_vr_fifo;
  logic clk_i = 1'b0, rstn_i = 1'b0, clear_i = 1'b0;
  logic up_valid_i = 1'b0, dn_ready_i = 1'b0;
  logic [7:0] up_data_i = '0;
  logic up_ready_o, dn_valid_o, almost_full_o, almost_empty_o;
  logic [7:0] dn_data_o;
  logic [3:0] level_o;
  int checks = 0, failures = 0;

  vr_fifo #(.WIDTH(8), .DEPTH(10)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .clear_i(clear_i),
    .up_valid_i(up_valid_i), .up_data_i(up_data_i), .up_ready_o(up_ready_o),
    .dn_valid_o(dn_valid_o), .dn_data_o(dn_data_o), .dn_ready_i(dn_ready_i),
    .level_o(level_o), .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    #2;
    checks++; if (level_o !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level_o); end
    checks++; if (up_ready_o !== 1'b1) begin failures++; $display("FAIL reset_up_ready got=%b exp=1", up_ready_o); end
    checks++; if (dn_valid_o !== 1'b0) begin failures++; $display("FAIL reset_dn_valid got=%b exp=0", dn_valid_o); end
    checks++; if (almost_empty_o !== 1'b1) begin failures++; $display("FAIL reset_ae got=%b exp=1", almost_empty_o); end
    checks++; if (almost_full_o !== 1'b0) begin failures++; $display("FAIL reset_af got=%b exp=0", almost_full_o); end
    step();
    rstn_i = 1'b1;
    step();
  endtask

  task automatic test_fill();
    dn_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      up_valid_i = 1'b1;
      up_data_i = 8'(i + 1);
      #1;
      checks++; if (up_ready_o !== 1'b1) begin failures++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, up_ready_o); end
      step();
      checks++; if (level_o !== 4'(i + 1)) begin failures++; $display("FAIL fill_level got=%0d exp=%0d", level_o, i + 1); end
      checks++; if (almost_full_o !== (i + 1 >= 8)) begin failures++; $display("FAIL fill_af at level %0d got=%b", i + 1, almost_full_o); end
      checks++; if (almost_empty_o !== (i + 1 <= 1)) begin failures++; $display("FAIL fill_ae at level %0d got=%b", i + 1, almost_empty_o); end
    end
    up_data_i = 8'h0B;
    #1;
    checks++; if (up_ready_o !== 1'b0) begin failures++; $display("FAIL full_up_ready got=%b exp=0", up_ready_o); end
    step();
    checks++; if (level_o !== 4'd10) begin failures++; $display("FAIL full_hold_level got=%0d exp=10", level_o); end
    checks++; if (dn_data_o !== 8'h01) begin failures++; $display("FAIL full_head got=%h exp=01", dn_data_o); end
  endtask

  task automatic test_full_pop_push();
    dn_ready_i = 1'b1;
    #1;
    checks++; if (up_ready_o !== 1'b0) begin failures++; $display("FAIL fullpop_up_ready got=%b exp=0", up_ready_o); end
    checks++; if (dn_valid_o !== 1'b1 || dn_data_o !== 8'h01) begin failures++; $display("FAIL fullpop_head got=%b/%h exp=1/01", dn_valid_o, dn_data_o); end
    step();
    checks++; if (level_o !== 4'd9) begin failures++; $display("FAIL fullpop_level got=%0d exp=9", level_o); end
    dn_ready_i = 1'b0;
    #1;
    checks++; if (up_ready_o !== 1'b1) begin failures++; $display("FAIL pending_ready got=%b exp=1", up_ready_o); end
    step();
    checks++; if (level_o !== 4'd10) begin failures++; $display("FAIL pending_level got=%0d exp=10", level_o); end
    up_valid_i = 1'b0;
    dn_ready_i = 1'b1;
    for (int i = 2; i <= 11; i++) begin
      #1;
      checks++; if (dn_valid_o !== 1'b1 || dn_data_o !== 8'(i)) begin failures++; $display("FAIL drain got=%b/%h exp=1/%h", dn_valid_o, dn_data_o, 8'(i)); end
      step();
    end
    checks++; if (level_o !== 4'd0 || dn_valid_o !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0d/%b exp=0/0", level_o, dn_valid_o); end
  endtask

  task automatic test_stream();
    int n_in = 0, n_out = 0, cyc = 0;
    dn_ready_i = 1'b1;
    while (n_out < 25 && cyc < 300) begin
      up_valid_i = (n_in < 25) ? 1'($urandom_range(0, 1)) : 1'b0;
      up_data_i = 8'(8'h20 + n_in);
      #1;
      if (dn_valid_o) begin
        checks++; if (dn_data_o !== 8'(8'h20 + n_out)) begin failures++; $display("FAIL stream_data[%0d] got=%h exp=%h", n_out, dn_data_o, 8'(8'h20 + n_out)); end
        n_out++;
      end
      if (up_valid_i && up_ready_o) n_in++;
      step();
      cyc++;
    end
    up_valid_i = 1'b0;
    checks++; if (n_out != 25) begin failures++; $display("FAIL stream_count got=%0d exp=25", n_out); end
  endtask

  task automatic test_clear();
    dn_ready_i = 1'b0;
    up_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      up_data_i = 8'(8'h40 + i);
      step();
    end
    checks++; if (level_o !== 4'd5) begin failures++; $display("FAIL clear_pre_level got=%0d exp=5", level_o); end
    clear_i = 1'b1;
    #1;
    checks++; if (up_ready_o !== 1'b0 || dn_valid_o !== 1'b0) begin failures++; $display("FAIL clear_handshake got=%b/%b exp=0/0", up_ready_o, dn_valid_o); end
    step();
    clear_i = 1'b0;
    up_valid_i = 1'b0;
    #1;
    checks++; if (level_o !== 4'd0 || almost_empty_o !== 1'b1 || dn_valid_o !== 1'b0) begin failures++; $display("FAIL clear_after got=%0d/%b/%b exp=0/1/0", level_o, almost_empty_o, dn_valid_o); end
  endtask

  task automatic test_async_reset();
    dn_ready_i = 1'b0;
    up_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      up_data_i = 8'(8'h60 + i);
      step();
    end
    checks++; if (level_o !== 4'd6) begin failures++; $display("FAIL areset_pre_level got=%0d exp=6", level_o); end
    #2;
    rstn_i = 1'b0;
    #1;
    checks++; if (level_o !== 4'd0 || dn_valid_o !== 1'b0 || up_ready_o !== 1'b1) begin failures++; $display("FAIL areset_immediate got=%0d/%b/%b exp=0/0/1", level_o, dn_valid_o, up_ready_o); end
    step();
    checks++; if (level_o !== 4'd0) begin failures++; $display("FAIL areset_no_write got=%0d exp=0", level_o); end
    up_valid_i = 1'b0;
    rstn_i = 1'b1;
    step();
  endtask

  task automatic test_bypass();
    up_valid_i = 1'b1;
    up_data_i = 8'h5A;
    dn_ready_i = 1'b1;
    #1;
`ifdef VR_FIFO_BYPASS_EN
    checks++; if (dn_valid_o !== 1'b1 || dn_data_o !== 8'h5A) begin failures++; $display("FAIL bypass_same got=%b/%h exp=1/5a", dn_valid_o, dn_data_o); end
    step();
    up_valid_i = 1'b0;
    #1;
    checks++; if (level_o !== 4'd0 || dn_valid_o !== 1'b0) begin failures++; $display("FAIL bypass_level got=%0d/%b exp=0/0", level_o, dn_valid_o); end
`else
    checks++; if (dn_valid_o !== 1'b0) begin failures++; $display("FAIL nobypass_same got=%b exp=0", dn_valid_o); end
    step();
    up_valid_i = 1'b0;
    #1;
    checks++; if (dn_valid_o !== 1'b1 || dn_data_o !== 8'h5A || level_o !== 4'd1) begin failures++; $display("FAIL nobypass_next got=%b/%h/%0d exp=1/5a/1", dn_valid_o, dn_data_o, level_o); end
    step();
    checks++; if (level_o !== 4'd0 || dn_valid_o !== 1'b0) begin failures++; $display("FAIL nobypass_drain got=%0d/%b exp=0/0", level_o, dn_valid_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_pop_push();
    test_stream();
    test_clear();
    test_async_reset();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vr_fifo.md
# vr_fifo

Parametrised valid/ready FIFO: next-generation buffer for the valid-credit to valid-ready converter path. Replaces raw push/pop strobes with a full handshake on both sides. Adds an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and an optional zero-latency bypass. Supports any DEPTH ≥ 2, including non-power-of-two, using wrap-at-DEPTH-1 pointers with a lap bit.

## Interface
- WIDTH, 8, data word width in bits
- DEPTH, 10, storage entries; ≥ 2, not necessarily a power of two
- AF_LEVEL, DEPTH-2, almost_full_o asserts when level ≥ AF_LEVEL; 1 ≤ AF_LEVEL ≤ DEPTH
- AE_LEVEL, 1, almost_empty_o asserts when level ≤ AE_LEVEL; 0 ≤ AE_LEVEL < AF_LEVEL
- LVL_W, $clog2(DEPTH+1), level output width (derived, not overridden)

Ports:
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous flush; empties the FIFO on the next edge
- up_valid_i  in  1  upstream word valid
- up_data_i  in  WIDTH  upstream word
- up_ready_o  out  1  FIFO accepts a word this cycle
- dn_valid_o  out  1  downstream word valid
- dn_data_o  out  WIDTH  downstream word
- dn_ready_i  in  1  downstream accepts
- level_o  out  LVL_W  stored word count, 0..DEPTH
- almost_full_o  out  1  level_o ≥ AF_LEVEL
- almost_empty_o  out  1  level_o ≤ AE_LEVEL

## Operation
- Write: wr = up_valid_i & up_ready_o. Read: rd = dn_valid_o & dn_ready_i.
- up_ready_o = ~full & ~clear_i. It has no combinational dependence on dn_ready_i. When full, a same-cycle pop does not admit a push.
- Storage: DEPTH×WIDTH register array, not reset. A write stores into mem[wr_ptr]. dn_data_o = mem[rd_ptr] (combinational read).
- Pointers: 0..DEPTH-1. An increment from DEPTH-1 wraps to 0 and toggles the lap bit.
  - empty = pointers equal and laps equal.
  - full = pointers equal and laps differ.
- level_o register: +1 on a stored write only, −1 on a stored read only, unchanged on both or neither. It always equals the pointer distance.
- Flags are combinational compares on the level_o register.
- clear_i has priority over all handshakes. Next edge: pointers, laps and level go to 0. Memory is untouched. While clear_i=1: up_ready_o=0 and dn_valid_o=0.
- Without bypass: dn_valid_o = ~empty & ~clear_i.

## Timing
- Reset values (asynchronous, while rstn_i=0):
  - level_o=0, up_ready_o=1, dn_valid_o=0
  - almost_empty_o=1, almost_full_o=0
  - dn_data_o undefined; benches must not check it when dn_valid_o=0
- Reset mid-operation discards all contents immediately. No handshake completes on the edge where rstn_i is low.
- Latency without bypass: a word written at edge N is visible on dn_valid_o/dn_data_o after edge N (next cycle).
- Throughput: one write and one read per cycle sustained when 0 < level < DEPTH.
- Stability: while dn_valid_o=1 and dn_ready_i=0, dn_data_o holds stable. Writes never target rd_ptr when non-empty.
- Wrap: a pointer at DEPTH-1 returns to 0 on its next step. For DEPTH=10, index 9 is followed by index 0.

## Configuration
- VR_FIFO_BYPASS_EN defined (bypass compiled in):
  - When empty and not clearing, dn_valid_o = up_valid_i and dn_data_o = up_data_i combinationally.
  - If dn_ready_i=1 in that cycle, the word passes through: no storage write, level stays 0.
  - If dn_ready_i=0, the word is stored normally.
  - Zero-cycle latency when empty.
- VR_FIFO_BYPASS_EN undefined: no combinational path from up_* to dn_*. Minimum latency 1 cycle.

## Test plan
- Reset, then fill with DEPTH=10 words 0x01..0x0A, dn_ready_i=0 → level_o steps 1..10. almost_full_o asserts at level 8. up_ready_o=0 at level 10. An 11th up_valid_i is held, not stored.
- Full FIFO, dn_ready_i=1 and up_valid_i=1 in the same cycle → one read only; level_o 10→9. The pending word is accepted the following cycle.
- Stream 25 words with both sides always ready and random up_valid_i → output order and values match input exactly across two pointer wraps (index 9→0).
- Level 5, assert clear_i for one cycle with up_valid_i=1 → up_ready_o=0 and dn_valid_o=0 that cycle. level_o=0 and almost_empty_o=1 next cycle.
- Drop rstn_i asynchronously mid-burst at level 6 → level_o=0, dn_valid_o=0 and up_ready_o=1 immediately, without waiting for a clock edge.
- Empty FIFO, up_valid_i=1 with data 0x5A, dn_ready_i=1 → with VR_FIFO_BYPASS_EN, dn_valid_o=1 and data 0x5A the same cycle, level_o stays 0. Without it, dn_valid_o=1 with 0x5A on the next cycle.
